// File: rtl/sseg_digit_scanner.sv
// sseg_digit_scanner -- time-multiplexed scan controller for a 4-digit
// seven-segment display.
//
// Holds a 16-bit hex value and walks one digit at a time, presenting the
// digit's nibble on num (to sseg_decoder) and its active-low anode on an.
// Loads are staged in a pending register and committed only at the frame
// wrap, so a displayed frame never mixes old and new digits.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   value[15:0] hex value, nibble k -> digit k (digit 0 rightmost)
//   load        single-cycle strobe capturing value
//   num[3:0]    nibble for the digit currently selected
//   an[3:0]     anode enables, active-low, an[k] -> digit k
//   frame_done  one-cycle pulse on the cycle after digit 3's slot ends
//
// Optional feature
//   SSEG_LEADING_ZERO_BLANK_EN  when defined, leading-zero digits 1..3 are
//                               blanked; digit 0 is always shown.
module sseg_digit_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt, pcnt_n;
  logic [1:0]    idx, idx_n;
  logic [15:0]   disp, disp_n;
  logic [15:0]   pend, pend_n;
  logic          pend_v, pend_v_n;
  logic          slot_end, wrap;
  logic [3:0]    num_n, an_n;

  assign slot_end = (pcnt == PMAX);
  assign wrap     = slot_end && (idx == 2'd3);

  // Next-state scan position and display/pending bookkeeping.
  always_comb begin
    pcnt_n   = slot_end ? '0 : pcnt + 1'b1;
    idx_n    = slot_end ? idx + 2'd1 : idx;
    disp_n   = disp;
    pend_n   = pend;
    pend_v_n = pend_v;
    if (load) begin
      if (wrap) begin
        // Load on the wrap cycle goes straight to the display; any staged
        // value is stale by definition and is dropped.
        disp_n   = value;
        pend_v_n = 1'b0;
      end else begin
        pend_n   = value;
        pend_v_n = 1'b1;
      end
    end else if (wrap && pend_v) begin
      disp_n   = pend;
      pend_v_n = 1'b0;
    end
  end

  // Outputs are computed from next state so they line up with the new slot
  // (and the freshly committed display value) on the same edge.
  always_comb begin
    num_n = disp_n[{idx_n, 2'b00} +: 4];
    an_n  = ~(4'b0001 << idx_n);
    // First cycle of every slot is a guard with all anodes off, hiding the
    // num transition from the previous digit.
    if (pcnt_n == '0) an_n = 4'b1111;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if ((idx_n != 2'd0) && ((disp_n >> {idx_n, 2'b00}) == 16'h0000))
      an_n = 4'b1111;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= 2'd0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_v     <= 1'b0;
      num        <= 4'h0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      idx        <= idx_n;
      disp       <= disp_n;
      pend       <= pend_n;
      pend_v     <= pend_v_n;
      num        <= num_n;
      an         <= an_n;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Testbench for sseg_digit_scanner (REFRESH_DIV=4). Directed scan, tear-free,
// collision, mid-frame reset and blanking scenarios plus randomized loads,
// all checked cycle by cycle against a frame-arithmetic reference model.
module tb_sseg_digit_scanner;
  localparam int D = 4;
  localparam int F = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  num, an;
  logic        frame_done;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: k = rising edges since reset release.
  int          k = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pv = 1'b0;

  sseg_digit_scanner #(.REFRESH_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .num(num), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // One clock: apply load/value, advance the model across the edge, check.
  task automatic step(input logic ld, input logic [15:0] v);
    logic       is_wrap;
    int         di;
    logic [3:0] e_an;
    load  = ld;
    value = v;
    @(posedge clk);
    is_wrap = ((k % F) == F - 1);
    if (ld) begin
      if (is_wrap) begin m_disp = v; m_pv = 1'b0; end
      else begin m_pend = v; m_pv = 1'b1; end
    end else if (is_wrap && m_pv) begin
      m_disp = m_pend; m_pv = 1'b0;
    end
    k++;
    di   = (k / D) % 4;
    e_an = 4'hF & ~(4'h1 << di);
    if ((k % D) == 0) e_an = 4'hF;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (di != 0 && (m_disp >> (4 * di)) == 16'h0) e_an = 4'hF;
`endif
    #1;
    chk("num", {12'h0, num}, (m_disp >> (4 * di)) & 16'hF);
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("frame_done", {15'h0, frame_done}, {15'h0, is_wrap});
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  // Idle until the model is at pre-edge frame position pos.
  task automatic until_pos(input int pos);
    for (int i = 0; i < F && (k % F) != pos; i++) step(1'b0, 16'h0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"}, {12'h0, an}, 16'h000F);
    chk({tag, "_num"}, {12'h0, num}, 16'h0000);
    chk({tag, "_fd"}, {15'h0, frame_done}, 16'h0000);
  endtask

  task automatic model_reset();
    k = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(5) == 0) step(1'b1, 16'($urandom));
      else step(1'b0, 16'h0);
    end
  endtask

  initial begin
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1 check_reset_state("rst");
    rst_n = 1'b1;
    model_reset();

    // Scan order with 1234 (load at k=0 commits at the first wrap).
    step(1'b1, 16'h1234);
    run(2 * F - 1);

    // Tear-free update: load ABCD during slot 1.
    until_pos(D + 1);
    step(1'b1, 16'hABCD);
    run(2 * F);

    // Collision: 1111 mid-frame, 2222 exactly on the wrap.
    until_pos(2 * D + 1);
    step(1'b1, 16'h1111);
    until_pos(F - 1);
    step(1'b1, 16'h2222);
    run(F);

    rand_run(300);
    // Random loads landing on the wrap cycle.
    for (int j = 0; j < 4; j++) begin
      until_pos(F - 1);
      step(1'b1, 16'($urandom));
      rand_run(7);
    end

    // Reset mid-frame during slot 2 with a pending load.
    until_pos(2 * D);
    step(1'b1, 16'h5A5A);
    step(1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    @(posedge clk);
    #1 check_reset_state("rst_hold");
    rst_n = 1'b1;
    model_reset();
    run(2 * F);

    // Leading-zero pattern (blanked when the feature is built in).
    step(1'b1, 16'h00A0);
    run(2 * F);
    step(1'b1, 16'h0000);
    run(2 * F);
    step(1'b1, 16'h0F00);
    run(2 * F);

    rand_run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout k=%0d", k);
    $fatal(1);
  end
endmodule
